// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: data widths, NOP encoding, reset PC and the buffer entry layout.
package inst_fetch_pkg;

  localparam int unsigned INST_WIDTH      = 32;
  localparam int unsigned INST_ADDR_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0]      INST_NOP         = 32'h0000_0013;
  localparam logic [INST_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_WIDTH-1:0] align_word(input logic [INST_ADDR_WIDTH-1:0] addr);
    return {addr[INST_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: small circular instruction buffer holding {inst, pc}; flush wins over push and pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/request generation with redirect handling, feeding fetch_fifo toward decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects are ignored and flagged on misalign_o.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned                BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                       inst_req_o,
  input  logic [INST_WIDTH-1:0]      inst_i,
  input  logic                       jump_en_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [INST_WIDTH-1:0]      id_inst_o,
  output logic [INST_ADDR_WIDTH-1:0] id_pc_o,
  output logic                       misalign_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                       inflight_q, inflight_d;
  logic                       misalign_q, misalign_d;

  logic                       redirect;
  logic [INST_ADDR_WIDTH-1:0] target;
  logic                       head_vld, pop, req;
  logic [CW-1:0]              count;
  int unsigned                occupancy;
  fetch_entry_t               head, wr_entry;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect   = jump_en_i & (jump_addr_i[1:0] == 2'b00);
    target     = jump_addr_i;
    misalign_d = misalign_q | (jump_en_i & (jump_addr_i[1:0] != 2'b00));
`else
    redirect   = jump_en_i;
    target     = align_word(jump_addr_i);
    misalign_d = 1'b0;
`endif
    pop = head_vld & id_ready_i & ~rst;
    // The pending response already owns a slot, so it counts against capacity.
    occupancy = 32'(count) + 32'(inflight_q) - 32'(pop);
    req       = ~rst & ~redirect & (occupancy < BUF_DEPTH);

    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = req;
    if (redirect) begin
      pc_d = target;
    end else if (req) begin
      pc_d      = pc_q + 32'd4;
      resp_pc_d = pc_q;
    end

    wr_entry.inst = inst_i;
    wr_entry.pc   = resp_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  // Redirect flushes the buffer, which also drops the response arriving this cycle.
  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .pop        (pop),
    .flush      (redirect),
    .wr_entry   (wr_entry),
    .head       (head),
    .head_valid (head_vld),
    .count      (count)
  );

  always_comb begin
    inst_addr_o = rst ? RESET_PC : pc_q;
    inst_req_o  = req;
    id_valid_o  = head_vld & ~rst;
    id_inst_o   = (head_vld & ~rst) ? head.inst : INST_NOP;
    id_pc_o     = (head_vld & ~rst) ? head.pc : '0;
    misalign_o  = misalign_q & ~rst;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch with a one-cycle-latency memory model (data = addr ^ A5A5_0000).
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic        inst_req_o;
  logic [31:0] inst_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_o (inst_addr_o),
    .inst_req_o  (inst_req_o),
    .inst_i      (inst_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .id_ready_i  (id_ready_i),
    .id_valid_o  (id_valid_o),
    .id_inst_o   (id_inst_o),
    .id_pc_o     (id_pc_o),
    .misalign_o  (misalign_o)
  );

  logic        mem_vld_q = 1'b0;
  logic [31:0] mem_addr_q = '0;
  always @(posedge clk) begin
    mem_vld_q  <= inst_req_o;
    mem_addr_q <= inst_addr_o;
  end
  assign inst_i = mem_vld_q ? (mem_addr_q ^ KEY) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [31:0] ja;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic j, input logic [31:0] ja, input logic rd,
                     input logic q, input logic [31:0] a, input logic v, input logic [31:0] p,
                     input logic m);
    vec_t t;
    t.rst = r; t.jmp = j; t.ja = ja; t.rdy = rd;
    t.e_req = q; t.e_addr = a; t.e_val = v; t.e_pc = p; t.e_mis = m;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          pops;
    logic [31:0] exp_next;
    logic [31:0] ei;

    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;

    //  rst j  ja            rdy  req addr          val pc            mis
    add(1, 0, 32'h0,     1,  0, 32'h0,     0, 32'h0,     0);
    add(1, 0, 32'h0,     1,  0, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h4,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h8,     1, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'hC,     1, 32'h4,     0);
    add(0, 0, 32'h0,     1,  1, 32'h10,    1, 32'h8,     0);
    add(0, 0, 32'h0,     1,  1, 32'h14,    1, 32'hC,     0);
    add(0, 1, 32'h100,   1,  0, 32'h18,    1, 32'h10,    0);
    add(0, 0, 32'h0,     1,  1, 32'h100,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h104,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h108,   1, 32'h100,   0);
    add(0, 0, 32'h0,     1,  1, 32'h10C,   1, 32'h104,   0);
    add(0, 1, 32'h200,   1,  0, 32'h110,   1, 32'h108,   0);
    add(0, 1, 32'h300,   1,  0, 32'h200,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h300,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h304,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h308,   1, 32'h300,   0);
    add(0, 0, 32'h0,     1,  1, 32'h30C,   1, 32'h304,   0);
    add(1, 0, 32'h0,     1,  0, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h4,     0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h8,     1, 32'h0,     0);
    add(1, 0, 32'h0,     0,  0, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     0,  1, 32'h0,     0, 32'h0,     0);
    add(0, 0, 32'h0,     0,  1, 32'h4,     0, 32'h0,     0);
    add(0, 0, 32'h0,     0,  0, 32'h8,     1, 32'h0,     0);
    add(0, 0, 32'h0,     0,  0, 32'h8,     1, 32'h0,     0);
    add(0, 0, 32'h0,     0,  0, 32'h8,     1, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h8,     1, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'hC,     1, 32'h4,     0);
    add(0, 0, 32'h0,     1,  1, 32'h10,    1, 32'h8,     0);
    add(0, 0, 32'h0,     0,  0, 32'h14,    1, 32'hC,     0);
    add(0, 0, 32'h0,     1,  1, 32'h14,    1, 32'hC,     0);
    add(0, 0, 32'h0,     1,  1, 32'h18,    1, 32'h10,    0);
`ifdef FETCH_MISALIGN_CHECK_EN
    add(0, 1, 32'h102,   1,  1, 32'h1C,    1, 32'h14,    0);
    add(0, 0, 32'h0,     1,  1, 32'h20,    1, 32'h18,    1);
    add(0, 0, 32'h0,     1,  1, 32'h24,    1, 32'h1C,    1);
    add(0, 0, 32'h0,     1,  1, 32'h28,    1, 32'h20,    1);
`else
    add(0, 1, 32'h102,   1,  0, 32'h1C,    1, 32'h14,    0);
    add(0, 0, 32'h0,     1,  1, 32'h100,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h104,   0, 32'h0,     0);
    add(0, 0, 32'h0,     1,  1, 32'h108,   1, 32'h100,   0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst         = vecs[i].rst;
      jump_en_i   = vecs[i].jmp;
      jump_addr_i = vecs[i].ja;
      id_ready_i  = vecs[i].rdy;
      @(negedge clk);
      ei = vecs[i].e_val ? (vecs[i].e_pc ^ KEY) : NOP;
      chk("inst_req",   i, 32'(inst_req_o), 32'(vecs[i].e_req));
      chk("inst_addr",  i, inst_addr_o,     vecs[i].e_addr);
      chk("id_valid",   i, 32'(id_valid_o), 32'(vecs[i].e_val));
      chk("id_pc",      i, id_pc_o,         vecs[i].e_pc);
      chk("id_inst",    i, id_inst_o,       ei);
      chk("misalign",   i, 32'(misalign_o), 32'(vecs[i].e_mis));
    end

    // Intermittent backpressure: head must track the model's next PC, no gaps or repeats.
    @(posedge clk); #1;
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!id_valid_o && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_valid_cycle", 0, 32'(cyc), 32'd2);

    exp_next = 32'h0;
    pops     = 0;
    for (int k = 0; k < 30; k++) begin
      if (id_valid_o) begin
        chk("stream_pc",   k, id_pc_o,   exp_next);
        chk("stream_inst", k, id_inst_o, exp_next ^ KEY);
        if (id_ready_i) begin
          exp_next = exp_next + 32'd4;
          pops++;
        end
      end
      @(posedge clk); #1;
      id_ready_i = ((k % 3) != 2);
      @(negedge clk);
    end
    chk("stream_progress", 0, 32'(pops >= 10), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries (power of two, 2..8).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high (`RST = 1, `UNRST = 0).
REQ-005 inst_addr_o  out  `INST_ADDR_WIDTH  fetch address to instruction memory.
REQ-006 inst_req_o  out  1  fetch request valid this cycle.
REQ-007 inst_i  in  `INST_WIDTH  memory read data, valid exactly one cycle after a request.
REQ-008 jump_en_i  in  1  redirect from execute.
REQ-009 jump_addr_i  in  `INST_ADDR_WIDTH  redirect target.
REQ-010 id_ready_i  in  1  decode accepts id_inst_o this cycle.
REQ-011 id_valid_o  out  1  buffer head valid.
REQ-012 id_inst_o  out  `INST_WIDTH  head instruction; 32'h0000_0013 (NOP) when id_valid_o = 0.
REQ-013 id_pc_o  out  `INST_ADDR_WIDTH  address of head instruction; 0 when id_valid_o = 0.
REQ-014 misalign_o  out  1  misaligned redirect flag (see Configuration).

Function
REQ-015 inst_addr_o SHALL be the registered PC; PC advances by 4 on each issued request.
REQ-016 inst_req_o SHALL assert when count + inflight - pop < BUF_DEPTH and no redirect this cycle; pop = id_valid_o & id_ready_i.
REQ-017 Response in cycle N+1 to a request in cycle N SHALL be written to the buffer tail with its PC, unless discarded.
REQ-018 Pop and push in the same cycle SHALL both take effect; count unchanged.
REQ-019 Buffer SHALL never overflow; read/write pointers wrap modulo BUF_DEPTH.
REQ-020 Latency: request in cycle N -> id_valid_o at cycle N+2 (no bypass).
REQ-021 Steady state with id_ready_i = 1: one instruction per cycle, consecutive PCs.
REQ-022 id_ready_i = 0: head held stable (inst, pc, valid) until accepted.
REQ-023 jump_en_i in cycle N SHALL: flush buffer, set PC = jump_addr_i at edge N, suppress request in N, mark response arriving in N+1 for discard.
REQ-024 Redirect SHALL take priority over simultaneous pop and push; a pop in cycle N is still consumed by decode.
REQ-025 After redirect in N: request jump_addr_i in N+1, id_valid_o = 0 in N+1..N+2, target valid at N+3.
REQ-026 Back-to-back redirects: latest target wins; each discards the preceding in-flight response.

Reset
REQ-027 While rst = 1: PC = RESET_PC, buffer empty, inflight = 0, inst_req_o = 0, id_valid_o = 0, id_inst_o = NOP, id_pc_o = 0, misalign_o = 0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight instructions; first cycle with rst = 0 requests RESET_PC.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: jump_en_i with jump_addr_i[1:0] != 0 sets misalign_o (sticky until reset), redirect ignored, fetch stream continues.
REQ-030 Macro undefined: misalign_o tied 0; jump_addr_i[1:0] forced to 0 when loaded into PC.

Structure
REQ-031 NOP encoding, RESET_PC default, and width macros SHALL live in the shared defines file.
REQ-032 Buffer SHALL be one sub-module fetch_fifo (push, pop, flush, data+pc, count); PC/request logic stays in inst_fetch.

Verification
REQ-033 Reset release, id_ready_i = 1, memory model returning addr^32'hA5A5_0000 -> inst_addr_o 0,4,8,...; id_valid_o first at cycle 2; id_pc_o 0,4,8 consecutively.
REQ-034 id_ready_i = 0 for 5 cycles after fill -> inst_req_o deasserts once count = 2; head stays pc 0 until ready returns; no lost or duplicate PCs.
REQ-035 jump_en_i = 1, jump_addr_i = 32'h0000_0100 at cycle 6 -> inst_addr_o = 0x100 at cycle 7; id_valid_o low cycles 7-8; id_pc_o = 0x100 at cycle 9; stale PC 0x18 never presented.
REQ-036 Redirects to 0x200 then 0x300 on consecutive cycles -> only 0x300 stream reaches decode.
REQ-037 rst pulsed one cycle mid-stream -> outputs at reset values next cycle; stream restarts at RESET_PC.
REQ-038 With FETCH_MISALIGN_CHECK_EN, jump to 0x102 -> misalign_o = 1, PC unaffected; without it, PC loads 0x100.
